// File: rtl/vram_sprite_line_arbiter_mem.sv
// Sprite line VRAM with NUM_CH round-robin arbitrated line readers.
// Word-wide writes from the loader side, full-line reads with a fixed
// 2-edge latency and a one-hot tagged return (rd_valid) on shared rd_data.
// Optional build macro: VRAM_WRITE_FORWARD_EN -- when defined, a write that
// lands on the same line at the same edge a read is accepted is merged into
// that read's data (write-first); otherwise the read returns the old word.
module vram_sprite_line_arbiter_mem #(
  parameter int WORD_W         = 16,
  parameter int WORDS_PER_LINE = 8,
  parameter int LINES          = 4096,
  parameter int NUM_CH         = 4,
  localparam int LINE_W        = WORD_W * WORDS_PER_LINE,
  localparam int LINE_AW       = $clog2(LINES),
  localparam int WORD_AW       = LINE_AW + $clog2(WORDS_PER_LINE)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [WORD_AW-1:0]          write_addr,
  input  logic [WORD_W-1:0]           write_data,
  input  logic                        write_enable,
  input  logic [NUM_CH-1:0]           rd_req,
  input  logic [NUM_CH*LINE_AW-1:0]   rd_addr,
  output logic [NUM_CH-1:0]           rd_grant,
  output logic [NUM_CH-1:0]           rd_valid,
  output logic [LINE_W-1:0]           rd_data
);

  localparam int WIDX_W = $clog2(WORDS_PER_LINE);
  localparam int PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  // Line count widened by one bit so the range compare never overflows.
  localparam logic [LINE_AW:0] LINES_V = (LINE_AW + 1)'(LINES);

  // Arbiter state and the winning request of the current cycle.
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   ptr_next;
  logic [PTR_W-1:0]   win;
  logic               accept;
  logic [LINE_AW-1:0] rd_line;
  logic               rd_in_range;
  logic [LINE_AW-1:0] rd_line_safe;

  // Write-side decode.
  logic [LINE_AW-1:0] wr_line;
  logic [WIDX_W-1:0]  wr_idx;
  logic               wr_in_range;
  logic               wr_en;

  // Pipeline stage between the RAM read and the output register.
  logic [NUM_CH-1:0]  s1_valid;
  logic               s1_in_range;
  logic [LINE_W-1:0]  ram_line;
  logic [LINE_W-1:0]  merged;

  assign wr_line      = write_addr[WORD_AW-1 -: LINE_AW];
  assign wr_idx       = write_addr[WIDX_W-1:0];
  assign wr_in_range  = ({1'b0, wr_line} < LINES_V);
  assign wr_en        = write_enable && !reset && wr_in_range;

  assign rd_in_range  = ({1'b0, rd_line} < LINES_V);
  // Out-of-range reads still cycle the RAM; the address is parked at 0 and
  // the result is zeroed at the output stage.
  assign rd_line_safe = rd_in_range ? rd_line : '0;

  // Round-robin scan from ptr upward with wrap; first requester wins.
  always_comb begin
    int c;
    c        = 0;
    rd_grant = '0;
    win      = '0;
    accept   = 1'b0;
    rd_line  = '0;
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        c = int'(ptr) + i;
        if (c >= NUM_CH) c = c - NUM_CH;
        if (!accept && rd_req[c]) begin
          accept      = 1'b1;
          rd_grant[c] = 1'b1;
          win         = PTR_W'(c);
          rd_line     = rd_addr[c*LINE_AW +: LINE_AW];
        end
      end
    end
  end

  // Pointer moves to the channel after the winner; holds when idle.
  always_comb begin
    ptr_next = ptr;
    if (accept) begin
      ptr_next = (int'(win) == NUM_CH - 1) ? '0 : win + 1'b1;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (reset) ptr <= '0;
    else       ptr <= ptr_next;
  end

  // One RAM bank per word lane: byte-lane style word writes, read-first
  // full-line read captured on the accept edge.
  for (genvar gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_bank
    logic [WORD_W-1:0] mem [LINES];
    logic [WORD_W-1:0] q;

    // Word write and registered read-first line read for this lane.
    always_ff @(posedge clk) begin
      if (wr_en && (wr_idx == WIDX_W'(gi))) mem[wr_line] <= write_data;
      if (accept) q <= mem[rd_line_safe];
    end

    assign ram_line[gi*WORD_W +: WORD_W] = q;
  end

  // Stage-1 tag: which channel owns the read now sitting in the RAM register.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid    <= '0;
      s1_in_range <= 1'b0;
    end else begin
      s1_valid    <= rd_grant;
      s1_in_range <= rd_in_range;
    end
  end

`ifdef VRAM_WRITE_FORWARD_EN
  logic              fwd_hit;
  logic [WORD_W-1:0] fwd_word;
  logic [WIDX_W-1:0] fwd_idx;

  // Capture a same-edge write to the line being read so it can be merged.
  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_hit  <= 1'b0;
      fwd_word <= '0;
      fwd_idx  <= '0;
    end else begin
      fwd_hit  <= accept && wr_en && (wr_line == rd_line);
      fwd_word <= write_data;
      fwd_idx  <= wr_idx;
    end
  end

  // Overlay the forwarded word on its lane of the RAM output.
  always_comb begin
    merged = ram_line;
    for (int i = 0; i < WORDS_PER_LINE; i++) begin
      if (fwd_hit && (fwd_idx == WIDX_W'(i))) merged[i*WORD_W +: WORD_W] = fwd_word;
    end
  end
`else
  assign merged = ram_line;
`endif

  // Output register: tagged valid every cycle, data only on a return.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid <= '0;
      rd_data  <= '0;
    end else begin
      rd_valid <= s1_valid;
      if (|s1_valid) rd_data <= s1_in_range ? merged : '0;
    end
  end

endmodule

// File: tb/tb_vram_sprite_line_arbiter_mem.sv
// Self-checking bench for vram_sprite_line_arbiter_mem (LINES=3000 build).
// A line-level reference memory plus a queue of due returns predicts grants,
// rd_valid and rd_data every cycle. Honours VRAM_WRITE_FORWARD_EN.
module tb_vram_sprite_line_arbiter_mem;

  localparam int WORD_W  = 16;
  localparam int WPL     = 8;
  localparam int LINES   = 3000;
  localparam int NUM_CH  = 4;
  localparam int LINE_W  = 128;
  localparam int LINE_AW = 12;
  localparam int WORD_AW = 15;

  logic                      clk = 1'b0;
  logic                      reset = 1'b1;
  logic [WORD_AW-1:0]        write_addr;
  logic [WORD_W-1:0]         write_data = '0;
  logic                      write_enable = 1'b0;
  logic [NUM_CH-1:0]         rd_req = '0;
  logic [NUM_CH*LINE_AW-1:0] rd_addr;
  logic [NUM_CH-1:0]         rd_grant;
  logic [NUM_CH-1:0]         rd_valid;
  logic [LINE_W-1:0]         rd_data;

  logic [LINE_AW-1:0] wline = '0;
  logic [2:0]         widx = '0;
  logic [LINE_AW-1:0] addr [NUM_CH] = '{default: '0};

  assign write_addr = {wline, widx};
  assign rd_addr    = {addr[3], addr[2], addr[1], addr[0]};

  vram_sprite_line_arbiter_mem #(
    .WORD_W(WORD_W), .WORDS_PER_LINE(WPL), .LINES(LINES), .NUM_CH(NUM_CH)
  ) dut (
    .clk(clk), .reset(reset),
    .write_addr(write_addr), .write_data(write_data), .write_enable(write_enable),
    .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_grant(rd_grant), .rd_valid(rd_valid), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int          ch;
    logic [127:0] data;
  } ret_t;

  int           vectors = 0;
  int           miscompares = 0;
  logic [127:0] ref_mem [4096];
  ret_t         q [$];
  logic [127:0] last_data = '0;
  int           ptr = 0;
  int           cyc = 0;
  int           last_w = -1;
  bit           out_known = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply_write();
    if (!reset && write_enable && (int'(wline) < LINES))
      ref_mem[wline][widx*WORD_W +: WORD_W] = write_data;
  endtask

  // One clock cycle: check outputs mid-cycle, update the model, advance.
  task automatic tick();
    logic [3:0]   exp_v;
    logic [127:0] exp_d;
    logic [3:0]   exp_g;
    logic [127:0] line_d;
    int w;
    @(negedge clk);
    exp_v = '0;
    exp_d = last_data;
    if (q.size() > 0 && q[0].due == cyc) begin
      exp_v     = 4'(1) << q[0].ch;
      exp_d     = q[0].data;
      last_data = q[0].data;
      void'(q.pop_front());
    end
    if (out_known) begin
      chk("rd_valid", {124'b0, rd_valid}, {124'b0, exp_v});
      chk("rd_data", rd_data, exp_d);
    end
    w = -1;
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        int c;
        c = (ptr + i) % NUM_CH;
        if (w < 0 && rd_req[c]) w = c;
      end
    end
    exp_g = '0;
    if (w >= 0) exp_g[w] = 1'b1;
    chk("rd_grant", {124'b0, rd_grant}, {124'b0, exp_g});
`ifdef VRAM_WRITE_FORWARD_EN
    apply_write();
`endif
    if (w >= 0) begin
      line_d = (int'(addr[w]) < LINES) ? ref_mem[addr[w]] : '0;
      q.push_back('{cyc + 2, w, line_d});
      ptr = (w + 1) % NUM_CH;
    end
`ifndef VRAM_WRITE_FORWARD_EN
    apply_write();
`endif
    last_w = w;
    if (reset) begin
      q.delete();
      last_data = '0;
      ptr       = 0;
      out_known = 1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    rd_req       = '0;
    write_enable = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rd_req       = '0;
    write_enable = 1'b0;
    reset        = 1'b1;
    tick();
    reset        = 1'b0;
  endtask

  initial begin
    // Power-on reset, then reset-state outputs.
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    idle(2);

    // Fill lines 0..127 with random words.
    for (int l = 0; l < 128; l++) begin
      for (int k = 0; k < WPL; k++) begin
        wline = LINE_AW'(l); widx = 3'(k);
        write_data = 16'($urandom); write_enable = 1'b1;
        tick();
      end
    end
    write_enable = 1'b0;

    // Read every line back on channel 0, back to back.
    for (int l = 0; l < 128; l++) begin
      rd_req = 4'b0001; addr[0] = LINE_AW'(l);
      tick();
    end
    idle(3);

    // All channels requesting continuously from reset.
    do_reset();
    for (int c = 0; c < NUM_CH; c++) addr[c] = LINE_AW'($urandom_range(0, 127));
    rd_req = 4'hF;
    for (int i = 0; i < 12; i++) tick();
    idle(3);

    // Only channels 1 and 3 request.
    do_reset();
    rd_req = 4'b1010;
    for (int i = 0; i < 6; i++) tick();
    idle(3);

    // Same-edge write/read collision on line 5.
    for (int k = 0; k < WPL; k++) begin
      wline = 12'd5; widx = 3'(k); write_data = 16'hAAAA; write_enable = 1'b1;
      tick();
    end
    wline = 12'd5; widx = 3'd2; write_data = 16'h1234; write_enable = 1'b1;
    rd_req = 4'b0100; addr[2] = 12'd5;
    tick();
    write_enable = 1'b0;
    tick();
    idle(3);

    // Range handling: line 2999 valid, line 3000 out of range.
    for (int k = 0; k < WPL; k++) begin
      wline = 12'd2999; widx = 3'(k); write_data = 16'($urandom); write_enable = 1'b1;
      tick();
    end
    wline = 12'd3000; widx = 3'd0; write_data = 16'h5555; write_enable = 1'b1;
    tick();
    write_enable = 1'b0;
    rd_req = 4'b0010; addr[1] = 12'd3000;
    tick();
    addr[1] = 12'd2999;
    tick();
    idle(3);

    // Reset while two reads are in flight.
    rd_req = 4'b0001; addr[0] = 12'd10;
    tick();
    rd_req = 4'b0010; addr[1] = 12'd11;
    tick();
    do_reset();
    idle(3);
    rd_req = 4'b0011; addr[0] = 12'd20; addr[1] = 12'd21;
    tick();
    tick();
    idle(3);

    // Randomised traffic: readers, writers and out-of-range reads mixed.
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (!rd_req[c] || last_w == c) begin
          rd_req[c] = 1'($urandom_range(0, 1));
          addr[c]   = ($urandom_range(0, 7) == 0) ? LINE_AW'($urandom_range(3000, 3100))
                                                  : LINE_AW'($urandom_range(0, 127));
        end
      end
      write_enable = 1'($urandom_range(0, 1));
      wline        = LINE_AW'($urandom_range(0, 127));
      widx         = 3'($urandom_range(0, 7));
      write_data   = 16'($urandom);
      tick();
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
